// File: rtl/adder.sv
//------------------------------------------------------------------------------
// Module   : adder
// Brief    : Registered unsigned/signed adder with carry-in, overflow flag,
//            valid qualifier and wrapping transaction counter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             valid_in,
  input  logic             signed_mode,
  output logic [WIDTH:0]   c,
  output logic             ovf,
  output logic             valid_out,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [CNT_W-1:0] count_one;

  // cin always enters as an unsigned 0/1, whatever the mode.
  always_comb begin
    a_ext     = {(signed_mode & a[WIDTH-1]), a};
    b_ext     = {(signed_mode & b[WIDTH-1]), b};
    cin_ext   = {{WIDTH{1'b0}}, cin};
    sum       = a_ext + b_ext + cin_ext;
    sum_ovf   = signed_mode ? (sum[WIDTH] ^ sum[WIDTH-1]) : sum[WIDTH];
    count_one = {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c         <= '0;
      ovf       <= 1'b0;
      valid_out <= 1'b0;
      count     <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        c     <= sum;
        ovf   <= sum_ovf;
        count <= count + count_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder.sv
//------------------------------------------------------------------------------
// Module   : tb_adder
// Brief    : Directed self-checking bench for adder (WIDTH=4, CNT_W=16).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_adder;

  localparam int WIDTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             valid_in = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH:0]   c;
  logic             ovf;
  logic             valid_out;
  logic [CNT_W-1:0] count;

  int compared   = 0;
  int mismatched = 0;
  int exp_count  = 0;

  adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .valid_in    (valid_in),
    .signed_mode (signed_mode),
    .c           (c),
    .ovf         (ovf),
    .valid_out   (valid_out),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge; outputs are read at the next falling edge.
  task automatic step(input int va, input int vb, input logic vcin, input logic vsm, input logic vv);
    a           = WIDTH'(va);
    b           = WIDTH'(vb);
    cin         = vcin;
    signed_mode = vsm;
    valid_in    = vv;
    @(negedge clk);
    if (vv) exp_count = (exp_count + 1) % 65536;
  endtask

  task automatic check_res(input string tag, input int ec, input logic eovf, input logic evo);
    check({tag, ".c"}, 32'(c), 32'(ec));
    check({tag, ".ovf"}, 32'(ovf), 32'(eovf));
    check({tag, ".valid_out"}, 32'(valid_out), 32'(evo));
    check({tag, ".count"}, 32'(count), 32'(exp_count));
  endtask

  initial begin
    @(negedge clk);
    check_res("reset", 0, 1'b0, 1'b0);
    rst = 1'b0;

    // Unsigned
    step(7, 9, 1'b0, 1'b0, 1'b1);   check_res("u_7p9", 16, 1'b1, 1'b1);
    step(15, 15, 1'b1, 1'b0, 1'b1); check_res("u_15p15c", 31, 1'b1, 1'b1);
    step(3, 4, 1'b0, 1'b0, 1'b1);   check_res("u_3p4", 7, 1'b0, 1'b1);

    // Signed (values written as 4-bit patterns)
    step(7, 1, 1'b0, 1'b1, 1'b1);   check_res("s_7p1", 8, 1'b1, 1'b1);
    step(8, 8, 1'b0, 1'b1, 1'b1);   check_res("s_m8pm8", 16, 1'b1, 1'b1);
    step(13, 2, 1'b0, 1'b1, 1'b1);  check_res("s_m3p2", 31, 1'b0, 1'b1);
    step(15, 0, 1'b1, 1'b1, 1'b1);  check_res("s_m1p0c", 0, 1'b0, 1'b1);
    step(7, 0, 1'b1, 1'b1, 1'b1);   check_res("s_7p0c", 8, 1'b1, 1'b1);

    // Valid gating 1,0,0,1
    step(1, 2, 1'b0, 1'b0, 1'b1);   check_res("gate0", 3, 1'b0, 1'b1);
    step(5, 5, 1'b0, 1'b0, 1'b0);   check_res("gate1", 3, 1'b0, 1'b0);
    step(9, 9, 1'b0, 1'b0, 1'b0);   check_res("gate2", 3, 1'b0, 1'b0);
    step(2, 2, 1'b0, 1'b0, 1'b1);   check_res("gate3", 4, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle, away from any rising edge
    valid_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    exp_count = 0;
    check_res("async_rst", 0, 1'b0, 1'b0);
    @(negedge clk);
    check_res("rst_held", 0, 1'b0, 1'b0);
    valid_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_res("post_rst_idle", 0, 1'b0, 1'b0);

    // All unsigned pairs back-to-back
    for (int i = 0; i < 256; i++) begin
      step(i / 16, i % 16, 1'b0, 1'b0, 1'b1);
      check("exh.c", 32'(c), 32'((i / 16) + (i % 16)));
      check("exh.ovf", 32'(ovf), 32'(((i / 16) + (i % 16)) >= 16));
    end
    check("exh.count", 32'(count), 32'(exp_count));

    // Counter wrap
    while (exp_count < 65535) step(1, 1, 1'b0, 1'b0, 1'b1);
    check("cnt_max", 32'(count), 32'd65535);
    step(1, 1, 1'b0, 1'b0, 1'b1);
    check("cnt_wrap", 32'(count), 32'd0);
    check("cnt_wrap.valid_out", 32'(valid_out), 32'd1);

    valid_in = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder.md
# adder

Registered unsigned/signed adder with a valid qualifier, carry-in, overflow flag and transaction counter. It is the arithmetic leaf of the layered adder testbench environment. The bench drives operands through the `adder_if` interface bundle, whose `a`, `b` and `c` signals connect directly to the like-named ports. Results are produced one clock after an accepted input.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits (legal range 2..32).
- `CNT_W`, default 16: width of the transaction counter.

Ports:
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in, added as +1 when high.
- `valid_in` input 1: qualifies `a`, `b`, `cin`, `signed_mode` for the current cycle.
- `signed_mode` input 1: 0 treats operands as unsigned; 1 treats them as two's complement.
- `c` output WIDTH+1: registered full-precision sum.
- `ovf` output 1: registered flag, high when the sum does not fit in WIDTH bits under the selected mode.
- `valid_out` output 1: high for one cycle when `c`/`ovf` carry a new result.
- `count` output CNT_W: number of accepted transactions, modulo 2^CNT_W.

`adder_if` bundles `clk`, `rst`, `a`, `b`, `c`. Its other signals are tied in the bench as `cin`=0, `valid_in`=1 and `signed_mode`=0.

## Operation
- An input is accepted on a rising `clk` edge when `valid_in`=1 and `rst`=0.
- **Unsigned mode** (`signed_mode`=0):
  - `c` = zero-extended `a` + zero-extended `b` + `cin`, computed in WIDTH+1 bits (no loss).
  - `ovf` = `c[WIDTH]`, i.e. the carry-out.
- **Signed mode** (`signed_mode`=1):
  - `c` = sign-extended `a` + sign-extended `b` + `cin`, computed in WIDTH+1 bits (two's complement, no loss).
  - `ovf` = `c[WIDTH] XOR c[WIDTH-1]`, i.e. the WIDTH-bit result overflowed.
- `cin` is always added as the unsigned value 0 or 1, never sign-extended.
- On an accepted input:
  - `c` and `ovf` are updated.
  - `valid_out` is set to 1.
  - `count` is incremented, wrapping from 2^CNT_W−1 to 0.
- On a cycle with `valid_in`=0:
  - `c` and `ovf` hold their previous values.
  - `valid_out` is set to 0.
  - `count` holds.
- The datapath is purely combinational into a single output register stage; there is no backpressure and no internal FIFO.

## Timing
- **Latency:** 1 cycle. An input accepted at edge N appears on `c`/`ovf` with `valid_out`=1 after edge N; results are readable until edge N+1.
- **Throughput:** one result per cycle. Back-to-back `valid_in` produces back-to-back `valid_out`.
- **Reset:** `rst` high forces `c`=0, `ovf`=0, `valid_out`=0 and `count`=0 immediately, independent of `clk`.
  - Reset held: outputs stay at 0 and inputs are ignored.
  - Release: the first accepted input is on the first rising edge with `rst` low.
- **Reset mid-operation:** the pending result is discarded. No `valid_out` pulse follows release unless `valid_in`=1 at a post-release edge.
- **Mode switching:** `signed_mode` is sampled per transaction alongside the operands, so switching between consecutive cycles is legal.
- **Counter overflow** has no side effect beyond the wrap.

## Test plan
- **Reset:** assert `rst` mid-cycle with outputs nonzero -> `c`=0, `ovf`=0, `valid_out`=0, `count`=0 without waiting for a clock edge.
- **Unsigned carry (WIDTH=4):** a=7, b=9, cin=0, unsigned -> next cycle `c`=5'b10000 (16), `ovf`=1, `valid_out`=1, `count`=1.
- **Unsigned max with carry-in:** a=15, b=15, cin=1 -> `c`=31, `ovf`=1. Then a=3, b=4, cin=0 -> `c`=7, `ovf`=0.
- **Signed overflow:**
  - a=7, b=1 -> `c`=5'b01000 (+8), `ovf`=1.
  - a=−8, b=−8 -> `c`=5'b10000 (−16), `ovf`=1.
  - a=−3, b=2 -> `c`=5'b11111 (−1), `ovf`=0.
- **Valid gating:** valid_in pattern 1,0,0,1 -> `valid_out` pattern 1,0,0,1 one cycle later. `c` holds across the gap and `count` advances by exactly 2.
- **Exhaustive/wrap:** all 256 unsigned (a,b) pairs back-to-back, each checked against a+b. Preload 65535 transactions, then one more -> `count`=0.
